// File: rtl/bsg_concentrate_pkg.sv
// Shared definitions for the runtime-masked lane concentrator.
// Optional feature macro: BSG_CONCENTRATE_SCHED_PERF_EN (adds words_o/beats_o counters).
package bsg_concentrate_pkg;

  // Scheduler states, kept as plain constants for legacy-compatible encodings.
  localparam logic [0:0] eIDLE = 1'b0;
  localparam logic [0:0] eSEND = 1'b1;

  localparam int perf_width_lp = 32;

  typedef logic [perf_width_lp-1:0] perf_cnt_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic perf_cnt_t sat_inc(input perf_cnt_t cnt);
    return (cnt == '1) ? cnt : cnt + perf_cnt_t'(1);
  endfunction

endpackage

// File: rtl/bsg_concentrate_pick.sv
// Pending-mask decoder: lowest set lane index, its one-hot, and a flag that
// says this is the only lane left. Purely combinational.
module bsg_concentrate_pick
  import bsg_concentrate_pkg::*;
#(
  parameter int els_p     = 16,
  parameter int lg_els_lp = $clog2(els_p)
) (
  input  logic [els_p-1:0]     mask_i,
  output logic [lg_els_lp-1:0] idx_o,
  output logic [els_p-1:0]     one_hot_o,
  output logic                 last_o
);

  localparam logic [els_p-1:0] one_lp = els_p'(1);

  // Priority scan from the top down so the lowest set bit wins.
  always_comb begin
    // NOTE: default first so no path through this block leaves idx_o unassigned (no latch).
    idx_o = '0;
    for (int i = els_p - 1; i >= 0; i--) begin
      if (mask_i[i]) idx_o = lg_els_lp'(i);
    end
  end

  // Isolate lowest set bit; "exactly one" means clearing it leaves nothing.
  always_comb begin
    one_hot_o = mask_i & (~mask_i + one_lp);
    last_o    = (|mask_i) && ((mask_i & (mask_i - one_lp)) == '0);
  end

endmodule

// File: rtl/bsg_concentrate_sched.sv
// Runtime-masked lane concentrator: accepts one els_p-lane word with a keep
// mask and emits the kept lanes one per beat in ascending lane order.
// Optional feature macro: BSG_CONCENTRATE_SCHED_PERF_EN (words_o/beats_o).
module bsg_concentrate_sched
  import bsg_concentrate_pkg::*;
#(
  parameter int els_p     = 16,
  parameter int width_p   = 2,
  parameter int lg_els_lp = $clog2(els_p)
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [els_p*width_p-1:0] data_i,
  input  logic [els_p-1:0]         mask_i,
  input  logic                     v_i,
  output logic                     ready_o,
  output logic [width_p-1:0]       data_o,
  output logic [lg_els_lp-1:0]     idx_o,
  output logic                     last_o,
  output logic                     v_o,
  input  logic                     ready_i
`ifdef BSG_CONCENTRATE_SCHED_PERF_EN
  ,
  output logic [31:0]              words_o,
  output logic [31:0]              beats_o
`endif
);

  logic [0:0]               state_r;
  logic [els_p-1:0]         mask_r;
  logic [els_p*width_p-1:0] data_r;
  logic [els_p-1:0]         one_hot;
  logic                     consume;
  logic                     accept;
  logic                     load;

  bsg_concentrate_pick #(
    .els_p     (els_p),
    .lg_els_lp (lg_els_lp)
  ) pick (
    .mask_i    (mask_r),
    .idx_o     (idx_o),
    .one_hot_o (one_hot),
    .last_o    (last_o)
  );

  // Handshake: new words are taken while idle or on the final-beat handoff,
  // which lets back-to-back words run with no bubble.
  always_comb begin
    v_o     = (state_r == eSEND);
    consume = v_o & ready_i;
    ready_o = (state_r == eIDLE) | (consume & last_o);
    accept  = v_i & ready_o;
    load    = accept & (|mask_i);
    data_o  = data_r[idx_o*width_p +: width_p];
  end

  // FSM plus pending-mask/data registers; a load overrides the last-beat clear.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r <= eIDLE;
      mask_r  <= '0;
      // NOTE: the lane word is reset too so data_o reads zero out of reset, not X.
      data_r  <= '0;
    end else begin
      // NOTE: non-blocking here, so the later load assignment wins cleanly over the clear.
      if (consume) begin
        mask_r <= mask_r & ~one_hot;
        if (last_o) state_r <= eIDLE;
      end
      if (load) begin
        state_r <= eSEND;
        mask_r  <= mask_i;
        data_r  <= data_i;
      end
    end
  end

`ifdef BSG_CONCENTRATE_SCHED_PERF_EN
  perf_cnt_t words_r;
  perf_cnt_t beats_r;

  // Saturating activity counters: every accepted word (even empty), every consumed beat.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      words_r <= '0;
      beats_r <= '0;
    end else begin
      if (accept)  words_r <= sat_inc(words_r);
      if (consume) beats_r <= sat_inc(beats_r);
    end
  end

  assign words_o = words_r;
  assign beats_o = beats_r;
`endif

endmodule

// File: tb/tb_bsg_concentrate_sched.sv
// Directed, table-driven bench for bsg_concentrate_sched (els_p=16, width_p=2).
// Optional feature macro: BSG_CONCENTRATE_SCHED_PERF_EN (enables counter checks).
module tb_bsg_concentrate_sched;

  localparam int els_p   = 16;
  localparam int width_p = 2;
  localparam int lg_els  = 4;

  localparam logic [31:0] d1 = 32'hE4E4_E4E4; // lane k = k%4
  localparam logic [31:0] d2 = 32'h1B1B_1B1B; // lane k = 3-(k%4)

  logic                     clk = 1'b0;
  logic                     reset_i;
  logic [els_p*width_p-1:0] data_i;
  logic [els_p-1:0]         mask_i;
  logic                     v_i;
  logic                     ready_o;
  logic [width_p-1:0]       data_o;
  logic [lg_els-1:0]        idx_o;
  logic                     last_o;
  logic                     v_o;
  logic                     ready_i;
`ifdef BSG_CONCENTRATE_SCHED_PERF_EN
  logic [31:0]              words_o;
  logic [31:0]              beats_o;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  bsg_concentrate_sched #(
    .els_p   (els_p),
    .width_p (width_p)
  ) dut (
    .clk_i   (clk),
    .reset_i (reset_i),
    .data_i  (data_i),
    .mask_i  (mask_i),
    .v_i     (v_i),
    .ready_o (ready_o),
    .data_o  (data_o),
    .idx_o   (idx_o),
    .last_o  (last_o),
    .v_o     (v_o),
    .ready_i (ready_i)
`ifdef BSG_CONCENTRATE_SCHED_PERF_EN
    ,
    .words_o (words_o),
    .beats_o (beats_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              v;
    logic [31:0]       d;
    logic [15:0]       m;
    logic              r;
    logic              exp_v;
    logic              exp_ready;
    logic [lg_els-1:0] exp_idx;
    logic              exp_last;
    logic [1:0]        exp_data;
  } vec_t;

  vec_t tbl [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic [15:0] m, input logic r);
    v_i = v; data_i = d; mask_i = m; ready_i = r;
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat_check(input string name, input logic [3:0] idx, input logic last,
                            input logic [1:0] data);
    check({name, ".v_o"}, 32'(v_o), 32'd1);
    check({name, ".idx_o"}, 32'(idx_o), 32'(idx));
    check({name, ".last_o"}, 32'(last_o), 32'(last));
    check({name, ".data_o"}, 32'(data_o), 32'(data));
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset_i = 1'b0;
  endtask

  initial begin
    logic [3:0] edbf_idx [13];
    edbf_idx = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd7, 4'd8,
                 4'd10, 4'd11, 4'd13, 4'd14, 4'd15};

    // {v, data, mask, ready_i, exp_v, exp_ready, exp_idx, exp_last, exp_data}
    tbl[0]  = '{1'b1, d1,    16'h0000, 1'b1, 1'b0, 1'b1, 4'd0,  1'b0, 2'd0}; // empty word dropped
    tbl[1]  = '{1'b0, 32'h0, 16'h0000, 1'b1, 1'b0, 1'b1, 4'd0,  1'b0, 2'd0}; // no beat from it
    tbl[2]  = '{1'b1, d1,    16'h0003, 1'b1, 1'b0, 1'b1, 4'd0,  1'b0, 2'd0}; // accept 0003
    tbl[3]  = '{1'b1, d2,    16'h8000, 1'b1, 1'b1, 1'b0, 4'd0,  1'b0, 2'd0}; // v_i ignored
    tbl[4]  = '{1'b1, d2,    16'h8000, 1'b1, 1'b1, 1'b1, 4'd1,  1'b1, 2'd1}; // handoff
    tbl[5]  = '{1'b0, 32'h0, 16'h0000, 1'b1, 1'b1, 1'b1, 4'd15, 1'b1, 2'd0}; // second word
    tbl[6]  = '{1'b0, 32'h0, 16'h0000, 1'b1, 1'b0, 1'b1, 4'd0,  1'b0, 2'd0};
    tbl[7]  = '{1'b1, d2,    16'h0030, 1'b1, 1'b0, 1'b1, 4'd0,  1'b0, 2'd0}; // accept 0030
    tbl[8]  = '{1'b1, d1,    16'hFFFF, 1'b0, 1'b1, 1'b0, 4'd4,  1'b0, 2'd3}; // stall
    tbl[9]  = '{1'b1, d1,    16'hFFFF, 1'b0, 1'b1, 1'b0, 4'd4,  1'b0, 2'd3};
    tbl[10] = '{1'b1, d1,    16'hFFFF, 1'b0, 1'b1, 1'b0, 4'd4,  1'b0, 2'd3};
    tbl[11] = '{1'b0, 32'h0, 16'h0000, 1'b1, 1'b1, 1'b0, 4'd4,  1'b0, 2'd3};
    tbl[12] = '{1'b0, 32'h0, 16'h0000, 1'b1, 1'b1, 1'b1, 4'd5,  1'b1, 2'd2};
    tbl[13] = '{1'b0, 32'h0, 16'h0000, 1'b1, 1'b0, 1'b1, 4'd0,  1'b0, 2'd0};

    drive(1'b0, 32'h0, 16'h0, 1'b0);
    do_reset();

    // Reset state.
    check("rst.v_o", 32'(v_o), 32'd0);
    check("rst.ready_o", 32'(ready_o), 32'd1);
    check("rst.idx_o", 32'(idx_o), 32'd0);
    check("rst.last_o", 32'(last_o), 32'd0);
    check("rst.data_o", 32'(data_o), 32'd0);
`ifdef BSG_CONCENTRATE_SCHED_PERF_EN
    check("rst.words_o", words_o, 32'd0);
    check("rst.beats_o", beats_o, 32'd0);
`endif

    // Table: drop, back-to-back, stall.
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].v, tbl[i].d, tbl[i].m, tbl[i].r);
      #3;
      check($sformatf("vec%0d.v_o", i), 32'(v_o), 32'(tbl[i].exp_v));
      check($sformatf("vec%0d.ready_o", i), 32'(ready_o), 32'(tbl[i].exp_ready));
      check($sformatf("vec%0d.last_o", i), 32'(last_o), 32'(tbl[i].exp_last));
      if (tbl[i].exp_v) begin
        check($sformatf("vec%0d.idx_o", i), 32'(idx_o), 32'(tbl[i].exp_idx));
        check($sformatf("vec%0d.data_o", i), 32'(data_o), 32'(tbl[i].exp_data));
      end
`ifdef BSG_CONCENTRATE_SCHED_PERF_EN
      if (i == 1) begin
        check("perf.drop.words_o", words_o, 32'd1);
        check("perf.drop.beats_o", beats_o, 32'd0);
      end
`endif
      tick();
    end
`ifdef BSG_CONCENTRATE_SCHED_PERF_EN
    // Accepted words: rows 0, 2, 4, 7; beats: 3 + 2.
    check("perf.tbl.words_o", words_o, 32'd4);
    check("perf.tbl.beats_o", beats_o, 32'd5);
`endif

    // Mask EDBF: 13 beats, last only on idx 15.
    drive(1'b1, d1, 16'hEDBF, 1'b1);
    #3 check("edbf.accept.ready_o", 32'(ready_o), 32'd1);
    tick();
    drive(1'b0, 32'h0, 16'h0, 1'b1);
    for (int b = 0; b < 13; b++) begin
      #3 beat_check($sformatf("edbf%0d", b), edbf_idx[b], b == 12, edbf_idx[b][1:0]);
      tick();
    end
    #3 check("edbf.after.v_o", 32'(v_o), 32'd0);
    tick();

    // All-ones: els_p beats, idx 0..15.
    drive(1'b1, d2, 16'hFFFF, 1'b1);
    tick();
    drive(1'b0, 32'h0, 16'h0, 1'b1);
    for (int b = 0; b < 16; b++) begin
      #3 beat_check($sformatf("ones%0d", b), 4'(b), b == 15, 2'(3 - (b % 4)));
      tick();
    end
    #3 check("ones.after.v_o", 32'(v_o), 32'd0);
    tick();

    // Reset mid-word after 2 of 5 beats.
    drive(1'b1, d1, 16'h001F, 1'b1);
    tick();
    drive(1'b0, 32'h0, 16'h0, 1'b1);
    tick();
    tick();
    #3 beat_check("midrst.pre", 4'd2, 1'b0, 2'd2);
    reset_i = 1'b1;
    #1;
    check("midrst.v_o", 32'(v_o), 32'd0);
    check("midrst.ready_o", 32'(ready_o), 32'd1);
    @(negedge clk) reset_i = 1'b0;
    tick();
    drive(1'b1, d2, 16'h0014, 1'b1);
    tick();
    drive(1'b0, 32'h0, 16'h0, 1'b1);
    #3 beat_check("postrst0", 4'd2, 1'b0, 2'd1);
    tick();
    #3 beat_check("postrst1", 4'd4, 1'b1, 2'd3);
    tick();
    #3 check("postrst.after.v_o", 32'(v_o), 32'd0);

`ifdef BSG_CONCENTRATE_SCHED_PERF_EN
    // Saturation: push counters to one below max, then past it.
    force dut.words_r = 32'hFFFF_FFFE;
    force dut.beats_r = 32'hFFFF_FFFE;
    #1;
    release dut.words_r;
    release dut.beats_r;
    for (int w = 0; w < 2; w++) begin
      drive(1'b1, d1, 16'h0001, 1'b1);
      tick();
      drive(1'b0, 32'h0, 16'h0, 1'b1);
      tick();
      #1;
      check($sformatf("sat%0d.words_o", w), words_o, 32'hFFFF_FFFF);
      check($sformatf("sat%0d.beats_o", w), beats_o, 32'hFFFF_FFFF);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
